// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - issue/stall/flush sequencing for a 3-stage EX/MEM/WB back end
//
// Purpose: issues decode instructions into EX, stalls decode on RAW hazards
// found in the in-flight scoreboard, freezes the pipeline while a load/store
// waits on the memory handshake (with timeout), and flushes the wrong path on
// a taken branch/jump.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   dec_valid           decode holds a valid instruction
//   dec_rs1/rs2/rd      decoded register numbers
//   dec_op_data         flags: [1] uses rs1, [2] uses rs2, [3] uses rd,
//                       [4] branch, [5] jump, [7] load, [8] store
//   branch_taken        EX-stage redirect
//   mem_ack             memory access complete
//   issue               decode instruction enters EX at this edge
//   stall_if            hold PC and fetch/decode registers
//   flush               discard fetch/decode contents
//   mem_req             memory access outstanding
//   mem_err             one-cycle pulse on memory timeout
//   fwd_sel_rs1/rs2     EX operand source: 00 regfile, 01 MEM, 10 WB
//
// Configuration: define ISSUE_FWD_EN to enable operand forwarding (only
// load-use hazards stall). Undefined: full scoreboard interlock, fwd_sel = 00.

module issue_scheduler #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dec_valid,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic [4:0]  dec_rd,
   input  logic [14:0] dec_op_data,
   input  logic        branch_taken,
   input  logic        mem_ack,
   output logic        issue,
   output logic        stall_if,
   output logic        flush,
   output logic        mem_req,
   output logic        mem_err,
   output logic [1:0]  fwd_sel_rs1,
   output logic [1:0]  fwd_sel_rs2
);

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
      logic       st;
      logic       br;
   } stage_t;

   typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

   state_t     state;
   stage_t     ex_q, mem_q, wb_q;
   stage_t     dec_entry;
   logic [7:0] wait_cnt;

   logic uses_r1, uses_r2;
   logic timeout, advance, hazard, redirect, flush_c, issue_c;

   function automatic logic rd_hit(input stage_t s, input logic u1, input logic u2,
                                   input logic [4:0] r1, input logic [4:0] r2);
      // wr already excludes rd==0, so x0 can never match
      return s.v && s.wr && ((u1 && r1 == s.rd) || (u2 && r2 == s.rd));
   endfunction

   assign uses_r1 = dec_op_data[1];
   assign uses_r2 = dec_op_data[2];

   always_comb begin
      dec_entry    = '0;
      dec_entry.v  = 1'b1;
      dec_entry.rd = dec_rd;
      dec_entry.wr = dec_op_data[3] && (dec_rd != 5'd0);
      dec_entry.ld = dec_op_data[7];
      dec_entry.st = dec_op_data[8];
      dec_entry.br = dec_op_data[4] | dec_op_data[5];
   end

   // wait_cnt counts completed MEM_WAIT cycles; the timeout fires on the
   // cycle that brings it to MEM_TIMEOUT
   assign timeout = (state == MEM_WAIT) && (wait_cnt == 8'(MEM_TIMEOUT - 1));
   assign advance = (state == RUN) || ((state == MEM_WAIT) && (mem_ack || timeout));

`ifdef ISSUE_FWD_EN
   assign hazard = rd_hit(ex_q, uses_r1, uses_r2, dec_rs1, dec_rs2) && ex_q.ld;
`else
   assign hazard = rd_hit(ex_q,  uses_r1, uses_r2, dec_rs1, dec_rs2) ||
                   rd_hit(mem_q, uses_r1, uses_r2, dec_rs1, dec_rs2) ||
                   rd_hit(wb_q,  uses_r1, uses_r2, dec_rs1, dec_rs2);
`endif

   // a redirect is honoured whenever the branch actually leaves EX
   assign redirect = advance && branch_taken && ex_q.v && ex_q.br;
   assign flush_c  = (state == FLUSH) || redirect;
   assign issue_c  = dec_valid && advance && !hazard && !flush_c && (state != FLUSH);

   // gating with reset keeps every output low while reset is held
   assign issue    = !reset && issue_c;
   assign stall_if = !reset && dec_valid && !issue_c && (state != FLUSH) && !flush_c;
   assign flush    = !reset && flush_c;
   assign mem_err  = !reset && timeout && !mem_ack;
   assign mem_req  = (state == MEM_WAIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q     <= '0;
         mem_q    <= '0;
         wb_q     <= '0;
         state    <= RUN;
         wait_cnt <= 8'd0;
      end else if (advance) begin
         wb_q     <= mem_q;
         mem_q    <= ex_q;
         ex_q     <= issue_c ? dec_entry : '0;
         wait_cnt <= 8'd0;
         // a memory op moving into MEM (re)opens the handshake
         if (redirect)
            state <= FLUSH;
         else if (ex_q.v && (ex_q.ld || ex_q.st))
            state <= MEM_WAIT;
         else
            state <= RUN;
      end else if (state == FLUSH) begin
         state <= RUN;
      end else if (state == MEM_WAIT) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

`ifdef ISSUE_FWD_EN
   function automatic logic [1:0] fwd_src(input logic [4:0] rs, input stage_t ex_s,
                                          input stage_t mem_s);
      if (ex_s.v && ex_s.wr && rs == ex_s.rd)
         return 2'b01;
      else if (mem_s.v && mem_s.wr && rs == mem_s.rd)
         return 2'b10;
      else
         return 2'b00;
   endfunction

   // selects are evaluated against the stages as they stand at issue time:
   // what is in EX now becomes the MEM result, what is in MEM the WB result
   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_sel_rs1 <= 2'b00;
         fwd_sel_rs2 <= 2'b00;
      end else if (advance) begin
         fwd_sel_rs1 <= issue_c ? fwd_src(dec_rs1, ex_q, mem_q) : 2'b00;
         fwd_sel_rs2 <= issue_c ? fwd_src(dec_rs2, ex_q, mem_q) : 2'b00;
      end
   end
`else
   assign fwd_sel_rs1 = 2'b00;
   assign fwd_sel_rs2 = 2'b00;
`endif

   logic unused_ok;
   assign unused_ok = ^{dec_op_data[14:9], dec_op_data[6], dec_op_data[0], mem_q, wb_q};

endmodule
